// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters (0 = EX stage,
//   1 = auxiliary address/branch-target unit). Round-robin arbitration,
//   registered ALU control/operands, captured result returned to the
//   granted requester over a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   arst_n       reset, synchronous, active-low (sampled on clk only)
//   req_valid    [1:0] request valid per requester
//   req_ready    [1:0] request accept, one-hot or zero (combinational, IDLE only)
//   req_ctrl_0/1 [3:0] ALU control code per requester
//   req_a_0/1    operand A per requester
//   req_b_0/1    operand B per requester
//   alu_ctrl     registered control code to the ALU
//   alu_op_a/b   registered operands to the ALU
//   alu_result   combinational ALU result
//   alu_zero     combinational ALU zero flag
//   resp_valid   [1:0] response valid, one-hot or zero
//   resp_ready   [1:0] response accept per requester
//   resp_result  captured ALU result
//   resp_zero    captured zero flag
//   resp_err     requested control code was illegal (ADD was executed)
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_ctrl_0,
  input  logic [3:0]        req_ctrl_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_prio;
  logic              r_grant;
  logic              r_err;
  logic [3:0]        r_alu_ctrl;
  logic [DATA_W-1:0] r_alu_op_a;
  logic [DATA_W-1:0] r_alu_op_b;
  logic [DATA_W-1:0] r_resp_result;
  logic              r_resp_zero;
  logic              r_resp_err;

  logic              w_winner;
  logic [3:0]        w_ctrl;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [3:0]        w_ctrl_legal;
  logic              w_illegal;

  // Winner selection and control-code legalisation.
  always_comb begin
    // Under contention prio decides; otherwise the single active bit wins.
    w_winner = (req_valid == 2'b11) ? r_prio : req_valid[1];
    w_ctrl   = w_winner ? req_ctrl_1 : req_ctrl_0;
    w_a      = w_winner ? req_a_1 : req_a_0;
    w_b      = w_winner ? req_b_1 : req_b_0;

    // Codes outside the decoder's set execute as ADD and flag an error.
    case (w_ctrl)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7: begin
        w_ctrl_legal = w_ctrl;
        w_illegal    = 1'b0;
      end
      default: begin
        w_ctrl_legal = 4'd2;
        w_illegal    = 1'b1;
      end
    endcase

    req_ready = 2'b00;
    if (r_state == IDLE && req_valid != 2'b00) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state       <= IDLE;
      r_prio        <= 1'b0;
      r_grant       <= 1'b0;
      r_err         <= 1'b0;
      r_alu_ctrl    <= '0;
      r_alu_op_a    <= '0;
      r_alu_op_b    <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            r_alu_ctrl <= w_ctrl_legal;
            r_alu_op_a <= w_a;
            r_alu_op_b <= w_b;
            r_grant    <= w_winner;
            r_err      <= w_illegal;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          // ALU has had a full cycle on the registered operands.
          r_resp_result <= alu_result;
          r_resp_zero   <= alu_zero;
          r_resp_err    <= r_err;
          r_state       <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready completes the handshake.
          if (resp_ready[r_grant]) begin
            r_prio  <= ~r_grant;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid  = (r_state == RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_op_a    = r_alu_op_a;
  assign alu_op_b    = r_alu_op_b;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_err    = r_resp_err;

endmodule
